// File: rtl/fixed_rounder_stream.sv
// fixed_rounder_stream: multi-channel fixed-point rounder/narrower behind a
// valid/ready stream. Each channel is rounded from IWIDTH to OWIDTH bits with a
// per-beat rounding mode, then carried through PIPELINE elastic stages.
// Optional feature macro: FIXED_ROUNDER_STREAM_SATURATE_EN
//   defined   -> overflowing channels clamp to their maximum code, o_sat flags it
//   undefined -> overflow wraps modulo 2^OWIDTH, o_sat stays 0
//
// Handshake: a beat transfers on a rising clk edge where valid & ready are both
// high. A producer holding valid may not retract it until it transfers. Ready
// may depend combinationally on the consumer's ready (i_ready follows o_ready).
module fixed_rounder_stream #(
    parameter int IWIDTH   = 16,
    parameter int OWIDTH   = 10,
    parameter int CHANNELS = 1,
    parameter int PIPELINE = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_valid,
    output logic                         i_ready,
    input  logic                         i_signed,
    input  logic [1:0]                   i_mode,
    input  logic [CHANNELS*IWIDTH-1:0]   i_data,
    output logic                         o_valid,
    input  logic                         o_ready,
    output logic                         o_signed,
    output logic [CHANNELS*OWIDTH-1:0]   o_data,
    output logic [CHANNELS-1:0]          o_sat
);

    localparam int D = IWIDTH - OWIDTH;

    logic [CHANNELS*OWIDTH-1:0] w_rnd_data;
    logic [CHANNELS-1:0]        w_rnd_sat;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic [IWIDTH-1:0] w_in;
        assign w_in = i_data[k*IWIDTH +: IWIDTH];

        if (D > 0) begin : g_narrow
            logic [OWIDTH-1:0] w_trunc;
            logic [OWIDTH-1:0] w_sum;
            logic              w_half;
            logic              w_sticky;
            logic              w_neg;
            logic              w_inc;

            // Upper bits are the floor of the scaled value in both number formats
            assign w_trunc = w_in[IWIDTH-1:D];
            assign w_half  = w_in[D-1];
            assign w_neg   = i_signed & w_in[IWIDTH-1];

            if (D > 1) begin : g_sticky
                assign w_sticky = |w_in[D-2:0];
            end else begin : g_no_sticky
                assign w_sticky = 1'b0;
            end

            // Decide whether the floor value is bumped by one LSB for this mode
            always_comb begin
                w_inc = 1'b0;
                case (i_mode)
                    2'd0: w_inc = 1'b0;
                    2'd1: w_inc = w_neg ? (w_half & w_sticky) : w_half;
                    2'd2: w_inc = w_half & (w_sticky | w_trunc[0]);
                    2'd3: w_inc = w_neg & (w_half | w_sticky);
                    default: w_inc = 1'b0;
                endcase
            end

            assign w_sum = w_trunc + {{(OWIDTH-1){1'b0}}, w_inc};

`ifdef FIXED_ROUNDER_STREAM_SATURATE_EN
            logic [OWIDTH-1:0] w_max;
            logic              w_ovf;
            // Only an increment on the largest code can overflow
            assign w_max = i_signed ? {1'b0, {(OWIDTH-1){1'b1}}} : {OWIDTH{1'b1}};
            assign w_ovf = w_inc & (w_trunc == w_max);
            assign w_rnd_data[k*OWIDTH +: OWIDTH] = w_ovf ? w_max : w_sum;
            assign w_rnd_sat[k]                   = w_ovf;
`else
            assign w_rnd_data[k*OWIDTH +: OWIDTH] = w_sum;
            assign w_rnd_sat[k]                   = 1'b0;
`endif
        end else begin : g_widen
            // Widening is exact: zero-fill the new low bits
            assign w_rnd_data[k*OWIDTH +: OWIDTH] = OWIDTH'(w_in) << (OWIDTH - IWIDTH);
            assign w_rnd_sat[k]                   = 1'b0;
        end
    end

    logic [PIPELINE-1:0]        r_valid;
    logic [PIPELINE-1:0]        r_signed;
    logic [CHANNELS*OWIDTH-1:0] r_data [PIPELINE];
    logic [CHANNELS-1:0]        r_sat  [PIPELINE];

    logic [PIPELINE-1:0]        w_rdy;
    logic [PIPELINE-1:0]        w_inv;
    logic [PIPELINE-1:0]        w_dsg;
    logic [CHANNELS*OWIDTH-1:0] w_din  [PIPELINE];
    logic [CHANNELS-1:0]        w_dsat [PIPELINE];

    // A stage can take a new beat unless it and every stage after it are full
    // while the consumer is stalling
    always_comb begin
        for (int i = 0; i < PIPELINE; i++) begin
            w_rdy[i] = o_ready;
            for (int j = i; j < PIPELINE; j++) begin
                if (!r_valid[j]) begin
                    w_rdy[i] = 1'b1;
                end
            end
        end
    end

    // Select what each stage would load: the rounder for stage 0, else the previous stage
    always_comb begin
        w_inv[0]  = i_valid;
        w_dsg[0]  = i_signed;
        w_din[0]  = w_rnd_data;
        w_dsat[0] = w_rnd_sat;
        for (int i = 1; i < PIPELINE; i++) begin
            w_inv[i]  = r_valid[i-1];
            w_dsg[i]  = r_signed[i-1];
            w_din[i]  = r_data[i-1];
            w_dsat[i] = r_sat[i-1];
        end
    end

    // Stage registers: valid bits follow readiness, data only moves on a real load
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PIPELINE; i++) begin
                r_valid[i]  <= 1'b0;
                r_signed[i] <= 1'b0;
                r_data[i]   <= '0;
                r_sat[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < PIPELINE; i++) begin
                if (w_rdy[i]) begin
                    r_valid[i] <= w_inv[i];
                end
                if (w_rdy[i] && w_inv[i]) begin
                    r_signed[i] <= w_dsg[i];
                    r_data[i]   <= w_din[i];
                    r_sat[i]    <= w_dsat[i];
                end
            end
        end
    end

    assign i_ready  = !reset & w_rdy[0];
    assign o_valid  = r_valid[PIPELINE-1];
    assign o_signed = r_signed[PIPELINE-1];
    assign o_data   = r_data[PIPELINE-1];
    assign o_sat    = r_sat[PIPELINE-1];

endmodule

// File: tb/tb_fixed_rounder_stream.sv
// Testbench for fixed_rounder_stream: an 8->4 bit, 4-channel, 3-stage instance
// for rounding, backpressure, reset and random traffic, plus a 4->6 bit widening
// instance. Expected beats come from an integer-arithmetic rounding model.
module tb_fixed_rounder_stream;

    localparam int IW = 8;
    localparam int OW = 4;
    localparam int CH = 4;
    localparam int P  = 3;
    localparam int D  = IW - OW;
    localparam int BW = 1 + CH + CH*OW;
    localparam int PW = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic             i_valid, i_ready, i_signed, o_valid, o_ready, o_signed;
    logic [1:0]       i_mode;
    logic [CH*IW-1:0] i_data;
    logic [CH*OW-1:0] o_data;
    logic [CH-1:0]    o_sat;

    logic       w_i_valid, w_i_ready, w_i_signed, w_o_valid, w_o_ready, w_o_signed;
    logic [1:0] w_i_mode;
    logic [3:0] w_i_data;
    logic [5:0] w_o_data;
    logic [0:0] w_o_sat;

    fixed_rounder_stream #(.IWIDTH(IW), .OWIDTH(OW), .CHANNELS(CH), .PIPELINE(P)) u_dut (
        .clk(clk), .reset(reset),
        .i_valid(i_valid), .i_ready(i_ready), .i_signed(i_signed), .i_mode(i_mode), .i_data(i_data),
        .o_valid(o_valid), .o_ready(o_ready), .o_signed(o_signed), .o_data(o_data), .o_sat(o_sat)
    );

    fixed_rounder_stream #(.IWIDTH(4), .OWIDTH(6), .CHANNELS(1), .PIPELINE(PW)) u_wide (
        .clk(clk), .reset(reset),
        .i_valid(w_i_valid), .i_ready(w_i_ready), .i_signed(w_i_signed), .i_mode(w_i_mode), .i_data(w_i_data),
        .o_valid(w_o_valid), .o_ready(w_o_ready), .o_signed(w_o_signed), .o_data(w_o_data), .o_sat(w_o_sat)
    );

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    bit lat_chk = 1'b1;

    logic [BW-1:0] exp_q[$];
    int            acc_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: treat each sample as an integer, divide by 2^D and round by the
    // mode's rule, then clamp or wrap into OW bits
    function automatic logic [BW-1:0] ref_beat(input logic sgn, input logic [1:0] mode,
                                               input logic [CH*IW-1:0] d);
        logic [CH*OW-1:0] od;
        logic [CH-1:0]    os;
        int v, q, r, h, mx;
        for (int k = 0; k < CH; k++) begin
            v = sgn ? int'($signed(d[k*IW +: IW])) : int'(d[k*IW +: IW]);
            h = 1 << D;
            q = v >>> D;
            r = v - q*h;
            case (mode)
                2'd1: if ((v >= 0) ? (2*r >= h) : (2*r > h)) q++;
                2'd2: if ((2*r > h) || ((2*r == h) && ((q & 1) != 0))) q++;
                2'd3: if ((v < 0) && (r != 0)) q++;
                default: ;
            endcase
            mx = sgn ? (1 << (OW-1)) - 1 : (1 << OW) - 1;
            os[k] = 1'b0;
            if (q > mx) begin
`ifdef FIXED_ROUNDER_STREAM_SATURATE_EN
                q = mx;
                os[k] = 1'b1;
`endif
            end
            od[k*OW +: OW] = q[OW-1:0];
        end
        return {sgn, os, od};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: both handshakes are sampled mid-cycle, ahead of the edge that completes them
    always @(negedge clk) begin
        logic [BW-1:0] e;
        int a;
        if (reset) begin
            exp_q.delete();
            acc_q.delete();
        end else begin
            if (o_valid && o_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_extra_beat", 32'(o_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    check("sb_beat", 32'({o_signed, o_sat, o_data}), 32'(e));
                    if (lat_chk) check("sb_latency", 32'(cyc - a), 32'(P));
                end
            end
            if (i_valid && i_ready) begin
                exp_q.push_back(ref_beat(i_signed, i_mode, i_data));
                acc_q.push_back(cyc);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_directed(input string tag, input logic sgn, input logic [1:0] mode,
                                 input logic [7:0] din, input logic [3:0] exp_d, input logic exp_s);
        int k;
        bit seen;
        @(posedge clk); #1;
        i_valid = 1'b1; i_signed = sgn; i_mode = mode; i_data = {CH{din}};
        @(negedge clk);
        check({tag, "_iready"}, 32'(i_ready), 32'd1);
        @(posedge clk); #1;
        i_valid = 1'b0;
        seen = 1'b0;
        k = 0;
        while (!seen && k < 20) begin
            k++;
            @(negedge clk);
            if (o_valid) begin
                seen = 1'b1;
                check({tag, "_latency"}, 32'(k), 32'(P));
                check({tag, "_data"}, 32'(o_data[OW-1:0]), 32'(exp_d));
                check({tag, "_sat"}, 32'(o_sat[0]), 32'(exp_s));
                check({tag, "_signed"}, 32'(o_signed), 32'(sgn));
            end
        end
        if (!seen) check({tag, "_timeout"}, 32'(o_valid), 32'd1);
    endtask

    task automatic wait_idle(input int n);
        @(posedge clk); #1;
        i_valid = 1'b0;
        o_ready = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [CH*OW-1:0] hold;
        bit held;
        int acc, cnt;
        logic sat_exp;

        reset = 1'b1; i_valid = 1'b0; i_signed = 1'b0; i_mode = 2'd0; i_data = '0; o_ready = 1'b1;
        w_i_valid = 1'b0; w_i_signed = 1'b0; w_i_mode = 2'd0; w_i_data = 4'h0; w_o_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_iready_low", 32'(i_ready), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_ovalid", 32'(o_valid), 32'd0);
        check("rst_odata", 32'(o_data), 32'd0);
        check("rst_osat", 32'(o_sat), 32'd0);
        check("rst_osigned", 32'(o_signed), 32'd0);
        check("rst_iready_high", 32'(i_ready), 32'd1);

        // Unsigned 2.5 / 3.5 across modes
        send_directed("u28_m0", 1'b0, 2'd0, 8'h28, 4'h2, 1'b0);
        send_directed("u28_m1", 1'b0, 2'd1, 8'h28, 4'h3, 1'b0);
        send_directed("u28_m2", 1'b0, 2'd2, 8'h28, 4'h2, 1'b0);
        send_directed("u28_m3", 1'b0, 2'd3, 8'h28, 4'h2, 1'b0);
        send_directed("u38_m2", 1'b0, 2'd2, 8'h38, 4'h4, 1'b0);
        // Signed -2.5 across modes, and the neighbours just off the tie
        send_directed("sd8_m0", 1'b1, 2'd0, 8'hD8, 4'hD, 1'b0);
        send_directed("sd8_m1", 1'b1, 2'd1, 8'hD8, 4'hD, 1'b0);
        send_directed("sd8_m2", 1'b1, 2'd2, 8'hD8, 4'hE, 1'b0);
        send_directed("sd8_m3", 1'b1, 2'd3, 8'hD8, 4'hE, 1'b0);
        send_directed("sd9_m1", 1'b1, 2'd1, 8'hD9, 4'hE, 1'b0);
        send_directed("sd7_m1", 1'b1, 2'd1, 8'hD7, 4'hD, 1'b0);
        send_directed("sd7_m3", 1'b1, 2'd3, 8'hD7, 4'hE, 1'b0);
        // Overflow on the maximum code
`ifdef FIXED_ROUNDER_STREAM_SATURATE_EN
        sat_exp = 1'b1;
        send_directed("uf8_m1_ovf", 1'b0, 2'd1, 8'hF8, 4'hF, sat_exp);
        send_directed("s78_m1_ovf", 1'b1, 2'd1, 8'h78, 4'h7, sat_exp);
`else
        sat_exp = 1'b0;
        send_directed("uf8_m1_ovf", 1'b0, 2'd1, 8'hF8, 4'h0, sat_exp);
        send_directed("s78_m1_ovf", 1'b1, 2'd1, 8'h78, 4'h8, sat_exp);
`endif
        send_directed("s78_m0", 1'b1, 2'd0, 8'h78, 4'h7, 1'b0);
        wait_idle(4);

        // Backpressure: consumer stalls while the producer streams
        lat_chk = 1'b0;
        o_ready = 1'b0; acc = 0; cnt = 0; held = 1'b0; hold = '0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            i_valid = 1'b1; i_signed = 1'b0; i_mode = 2'(c);
            i_data = {8'(cnt + 3), 8'(cnt + 2), 8'(cnt + 1), 8'(cnt)} << 2;
            @(negedge clk);
            if (i_valid && i_ready) begin acc++; cnt += 4; end
            if (o_valid) begin
                if (held) check("bp_stable", 32'(o_data), 32'(hold));
                hold = o_data;
                held = 1'b1;
            end
        end
        check("bp_accepts", 32'(acc), 32'(P));
        check("bp_iready_low", 32'(i_ready), 32'd0);
        @(posedge clk); #1;
        i_valid = 1'b0; o_ready = 1'b1;
        for (int c = 0; c < P + 2; c++) begin
            @(negedge clk);
            check("bp_drain_valid", 32'(o_valid), (c < P) ? 32'd1 : 32'd0);
        end
        wait_idle(4);

        // Random traffic with random backpressure
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            i_valid  = ($urandom_range(0, 3) != 0);
            i_signed = 1'($urandom_range(0, 1));
            i_mode   = 2'($urandom_range(0, 3));
            i_data   = 32'($urandom);
            o_ready  = ($urandom_range(0, 3) != 0);
        end
        wait_idle(8);
        check("rand_drained", 32'(exp_q.size()), 32'd0);
        lat_chk = 1'b1;

        // Reset with two beats held in flight
        o_ready = 1'b0;
        @(posedge clk); #1;
        i_valid = 1'b1; i_signed = 1'b0; i_mode = 2'd1; i_data = {CH{8'h11}};
        @(posedge clk); #1;
        i_data = {CH{8'h22}};
        @(posedge clk); #1;
        i_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("mid_busy_before_reset", 32'(o_valid), 32'd1);
        check("mid_iready_in_reset", 32'(i_ready), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; o_ready = 1'b1;
        @(negedge clk);
        check("mid_ovalid", 32'(o_valid), 32'd0);
        check("mid_odata", 32'(o_data), 32'd0);
        check("mid_osat", 32'(o_sat), 32'd0);
        check("mid_osigned", 32'(o_signed), 32'd0);
        send_directed("post_reset", 1'b0, 2'd1, 8'h28, 4'h3, 1'b0);
        wait_idle(6);

        // Widening instance: exact left shift in every mode and format
        for (int s = 0; s < 2; s++) begin
            for (int m = 0; m < 4; m++) begin
                int k;
                bit seen;
                @(posedge clk); #1;
                w_i_valid = 1'b1; w_i_signed = 1'(s); w_i_mode = 2'(m); w_i_data = 4'hA;
                @(posedge clk); #1;
                w_i_valid = 1'b0;
                seen = 1'b0;
                k = 0;
                while (!seen && k < 10) begin
                    k++;
                    @(negedge clk);
                    if (w_o_valid) begin
                        seen = 1'b1;
                        check("widen_latency", 32'(k), 32'(PW));
                        check("widen_data", 32'(w_o_data), 32'h28);
                        check("widen_sat", 32'(w_o_sat), 32'd0);
                    end
                end
                if (!seen) check("widen_timeout", 32'(w_o_valid), 32'd1);
            end
        end

        wait_idle(6);
        check("final_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
